// File: rtl/dakika_ay_sayac_pkg.sv
// rtl/dakika_ay_sayac_pkg.sv - shared limits and step-direction helper for the minute/month slice
package dakika_ay_sayac_pkg;

    localparam int WIDTH = 6;

    localparam logic [WIDTH-1:0] DAKIKA_MAX = 6'd59;
    localparam logic [WIDTH-1:0] AY_MIN     = 6'd1;
    localparam logic [WIDTH-1:0] AY_MAX     = 6'd12;

    typedef enum logic [1:0] {
        YON_TUT  = 2'd0,
        YON_ARTI = 2'd1,
        YON_EKSI = 2'd2
    } yon_e;

    // Simultaneous up and down requests cancel out.
    function automatic yon_e yon_sec(input logic i_arti, input logic i_eksi);
        if (i_arti && !i_eksi) begin
            return YON_ARTI;
        end else if (i_eksi && !i_arti) begin
            return YON_EKSI;
        end
        return YON_TUT;
    endfunction

endpackage

// File: rtl/dakika_ay_sayac_buton_debounce.sv
// rtl/dakika_ay_sayac_buton_debounce.sv - button synchronizer plus stability-counter debouncer
module buton_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_buton,
    output logic o_seviye
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_sayac;
    logic                   r_seviye;
    logic                   w_senkron;

    assign w_senkron = r_sync[SYNC_STAGES-1];
    assign o_seviye  = r_seviye;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_buton};
        end
    end

    // Any cycle where the synced level agrees with the accepted one restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sayac  <= '0;
            r_seviye <= 1'b0;
        end else if (w_senkron == r_seviye) begin
            r_sayac <= '0;
        end else if (r_sayac == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_sayac  <= '0;
            r_seviye <= w_senkron;
        end else begin
            r_sayac <= r_sayac + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dakika_ay_sayac.sv
// rtl/dakika_ay_sayac.sv - minute (0..59) and month (1..12) counters with carry/borrow pulses
module dakika_ay_sayac
    import dakika_ay_sayac_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stop,
    input  logic             dakika_arttir,
    input  logic             arttir_buton,
    input  logic             azalt_buton,
    input  logic             ay_arttir,
    input  logic             ay_azalt,
    output logic [WIDTH-1:0] dakika,
    output logic             saat_arttir,
    output logic             saat_azalt,
    output logic [WIDTH-1:0] ay,
    output logic             yil_arttir,
    output logic             yil_azalt
);

    logic             w_arttir_db;
    logic             w_azalt_db;
    logic             w_arttir_olay;
    logic             w_azalt_olay;
    yon_e             w_dk_yon;
    yon_e             w_ay_yon;

    logic             r_arttir_once;
    logic             r_azalt_once;
    logic [WIDTH-1:0] r_dakika;
    logic [WIDTH-1:0] r_ay;
    logic             r_saat_arttir;
    logic             r_saat_azalt;
    logic             r_yil_arttir;
    logic             r_yil_azalt;

    buton_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_arttir_db (
        .clk     (clk),
        .reset   (reset),
        .i_buton (arttir_buton),
        .o_seviye(w_arttir_db)
    );

    buton_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_azalt_db (
        .clk     (clk),
        .reset   (reset),
        .i_buton (azalt_buton),
        .o_seviye(w_azalt_db)
    );

    assign w_arttir_olay = w_arttir_db & ~r_arttir_once;
    assign w_azalt_olay  = w_azalt_db & ~r_azalt_once;

    // Button events only count in edit mode; the seconds tick only counts while running.
    assign w_dk_yon = yon_sec(stop ? w_arttir_olay : dakika_arttir, stop & w_azalt_olay);
    assign w_ay_yon = yon_sec(ay_arttir, ay_azalt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arttir_once <= 1'b0;
            r_azalt_once  <= 1'b0;
        end else begin
            r_arttir_once <= w_arttir_db;
            r_azalt_once  <= w_azalt_db;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dakika      <= '0;
            r_saat_arttir <= 1'b0;
            r_saat_azalt  <= 1'b0;
        end else begin
            r_saat_arttir <= 1'b0;
            r_saat_azalt  <= 1'b0;
            case (w_dk_yon)
                YON_ARTI: begin
                    if (r_dakika == DAKIKA_MAX) begin
                        r_dakika      <= '0;
                        r_saat_arttir <= 1'b1;
                    end else begin
                        r_dakika <= r_dakika + 6'd1;
                    end
                end
                YON_EKSI: begin
                    if (r_dakika == '0) begin
                        r_dakika     <= DAKIKA_MAX;
                        r_saat_azalt <= 1'b1;
                    end else begin
                        r_dakika <= r_dakika - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ay         <= AY_MIN;
            r_yil_arttir <= 1'b0;
            r_yil_azalt  <= 1'b0;
        end else begin
            r_yil_arttir <= 1'b0;
            r_yil_azalt  <= 1'b0;
            case (w_ay_yon)
                YON_ARTI: begin
                    if (r_ay == AY_MAX) begin
                        r_ay         <= AY_MIN;
                        r_yil_arttir <= 1'b1;
                    end else begin
                        r_ay <= r_ay + 6'd1;
                    end
                end
                YON_EKSI: begin
                    if (r_ay == AY_MIN) begin
                        r_ay        <= AY_MAX;
                        r_yil_azalt <= 1'b1;
                    end else begin
                        r_ay <= r_ay - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dakika      = r_dakika;
    assign saat_arttir = r_saat_arttir;
    assign saat_azalt  = r_saat_azalt;
    assign ay          = r_ay;
    assign yil_arttir  = r_yil_arttir;
    assign yil_azalt   = r_yil_azalt;

endmodule

// File: tb/tb_dakika_ay_sayac.sv
// tb/tb_dakika_ay_sayac.sv - directed self-checking bench for dakika_ay_sayac
module tb_dakika_ay_sayac;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stop = 1'b0;
    logic       dakika_arttir = 1'b0;
    logic       arttir_buton = 1'b0;
    logic       azalt_buton = 1'b0;
    logic       ay_arttir = 1'b0;
    logic       ay_azalt = 1'b0;
    logic [5:0] dakika;
    logic       saat_arttir;
    logic       saat_azalt;
    logic [5:0] ay;
    logic       yil_arttir;
    logic       yil_azalt;

    int n_test = 0;
    int n_fail = 0;
    int n_sa = 0;
    int n_sz = 0;
    int n_ya = 0;
    int n_yz = 0;

    dakika_ay_sayac #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stop         (stop),
        .dakika_arttir(dakika_arttir),
        .arttir_buton (arttir_buton),
        .azalt_buton  (azalt_buton),
        .ay_arttir    (ay_arttir),
        .ay_azalt     (ay_azalt),
        .dakika       (dakika),
        .saat_arttir  (saat_arttir),
        .saat_azalt   (saat_azalt),
        .ay           (ay),
        .yil_arttir   (yil_arttir),
        .yil_azalt    (yil_azalt)
    );

    always #5 clk = ~clk;

    task automatic kontrol(input string etiket, input int gozlenen, input int beklenen);
        n_test++;
        if (gozlenen != beklenen) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", etiket, gozlenen, beklenen);
        end
    endtask

    // Advance n falling edges, tallying every pulse seen along the way.
    task automatic bekle(input int n);
        repeat (n) begin
            @(negedge clk);
            n_sa += int'(saat_arttir);
            n_sz += int'(saat_azalt);
            n_ya += int'(yil_arttir);
            n_yz += int'(yil_azalt);
        end
    endtask

    task automatic sayac_sifirla();
        n_sa = 0;
        n_sz = 0;
        n_ya = 0;
        n_yz = 0;
    endtask

    task automatic dk_tik();
        dakika_arttir = 1'b1;
        bekle(1);
        dakika_arttir = 1'b0;
    endtask

    task automatic ay_tik(input logic arti, input logic eksi);
        ay_arttir = arti;
        ay_azalt  = eksi;
        bekle(1);
        ay_arttir = 1'b0;
        ay_azalt  = 1'b0;
    endtask

    initial begin
        bekle(2);
        kontrol("rst_dakika", int'(dakika), 0);
        kontrol("rst_ay", int'(ay), 1);
        kontrol("rst_pulses", int'({saat_arttir, saat_azalt, yil_arttir, yil_azalt}), 0);
        reset = 1'b0;
        bekle(1);

        // Run mode: count 0 -> 59 -> 0.
        sayac_sifirla();
        for (int i = 1; i <= 59; i++) begin
            dk_tik();
            kontrol("tick_dakika", int'(dakika), i);
        end
        kontrol("tick_no_carry", n_sa, 0);
        dk_tik();
        kontrol("wrap_dakika", int'(dakika), 0);
        kontrol("wrap_saat_arttir", int'(saat_arttir), 1);
        bekle(1);
        kontrol("wrap_pulse_end", int'(saat_arttir), 0);
        kontrol("wrap_pulse_count", n_sa, 1);

        // Asynchronous reset mid-run at 37.
        for (int i = 0; i < 37; i++) dk_tik();
        kontrol("pre_rst_dakika", int'(dakika), 37);
        #2 reset = 1'b1;
        #1 kontrol("async_rst_dakika", int'(dakika), 0);
        @(negedge clk);
        reset = 1'b0;
        bekle(1);

        // Edit mode: seconds tick ignored, clean decrement press borrows 0 -> 59.
        stop = 1'b1;
        dk_tik();
        kontrol("stop_ignores_tick", int'(dakika), 0);
        sayac_sifirla();
        azalt_buton = 1'b1;
        bekle(6);
        kontrol("dec_before_latency", int'(dakika), 0);
        bekle(1);
        kontrol("dec_borrow_dakika", int'(dakika), 59);
        kontrol("dec_saat_azalt", int'(saat_azalt), 1);
        bekle(12);
        azalt_buton = 1'b0;
        bekle(10);
        kontrol("dec_held_dakika", int'(dakika), 59);
        kontrol("dec_pulse_count", n_sz, 1);

        // Bouncy increment press, then held: exactly one +1 (59 -> 0 wraps).
        sayac_sifirla();
        for (int i = 0; i < 6; i++) begin
            arttir_buton = (i % 2 == 0);
            bekle(1);
        end
        arttir_buton = 1'b1;
        bekle(20);
        arttir_buton = 1'b0;
        bekle(10);
        kontrol("bounce_dakika", int'(dakika), 0);
        kontrol("bounce_saat_arttir", n_sa, 1);
        kontrol("bounce_no_borrow", n_sz, 0);

        // Both buttons accepted in the same cycle: no change.
        sayac_sifirla();
        arttir_buton = 1'b1;
        azalt_buton  = 1'b1;
        bekle(12);
        arttir_buton = 1'b0;
        azalt_buton  = 1'b0;
        bekle(10);
        kontrol("both_btn_dakika", int'(dakika), 0);
        kontrol("both_btn_pulses", n_sa + n_sz, 0);

        // Run mode: button press discarded, not queued.
        stop = 1'b0;
        arttir_buton = 1'b1;
        bekle(12);
        arttir_buton = 1'b0;
        bekle(10);
        stop = 1'b1;
        bekle(10);
        kontrol("run_btn_ignored", int'(dakika), 0);

        // Month counter.
        sayac_sifirla();
        for (int i = 2; i <= 12; i++) begin
            ay_tik(1'b1, 1'b0);
            kontrol("ay_up", int'(ay), i);
        end
        kontrol("ay_up_no_carry", n_ya, 0);
        ay_tik(1'b1, 1'b0);
        kontrol("ay_wrap", int'(ay), 1);
        kontrol("ay_yil_arttir", int'(yil_arttir), 1);
        bekle(1);
        kontrol("ay_yil_arttir_end", int'(yil_arttir), 0);
        ay_tik(1'b0, 1'b1);
        kontrol("ay_borrow", int'(ay), 12);
        kontrol("ay_yil_azalt", int'(yil_azalt), 1);
        bekle(1);
        kontrol("ay_yil_azalt_end", int'(yil_azalt), 0);
        ay_tik(1'b0, 1'b1);
        kontrol("ay_down", int'(ay), 11);
        sayac_sifirla();
        ay_tik(1'b1, 1'b1);
        bekle(2);
        kontrol("ay_both_hold", int'(ay), 11);
        kontrol("ay_both_no_pulse", n_ya + n_yz, 0);
        kontrol("ay_dakika_intact", int'(dakika), 0);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
